// File: rtl/ctrl_mc.sv
// Multicycle control FSM for the SISC processor: decodes opcode/mm, samples stat
// in DECODE, and drives register-file, ALU, PC, IR and data-memory strobes.
module ctrl_mc #(
  parameter int OPC_W  = 4,
  parameter int MM_W   = 4,
  parameter int IMM_MM = 8
) (
  input  logic             clk,
  input  logic             rst_f,
  input  logic [OPC_W-1:0] opcode,
  input  logic [MM_W-1:0]  mm,
  input  logic [MM_W-1:0]  stat,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             dm_we,
  output logic             mm_sel,
  output logic             rf_we,
  output logic [1:0]       alu_op,
  output logic [1:0]       wb_sel,
  output logic             rb_sel,
  output logic             br_sel,
  output logic             ir_load,
  output logic             pc_sel,
  output logic             pc_write,
  output logic             pc_rst,
  output logic             halted
);

  // state   | meaning
  // START   | clear PC after reset
  // FETCH   | read instruction at PC, wait for mem_ready
  // DECODE  | resolve branches, dispatch
  // EXECUTE | ALU operation or address calculation
  // MEM     | data access for LOD/STR, wait for mem_ready
  // WB      | register writeback (ALU, load, first swap half)
  // WB2     | second swap writeback
  // HALT    | stopped until reset
  typedef enum logic [2:0] {
    S_START, S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WB, S_WB2, S_HALT
  } state_t;

  localparam logic [OPC_W-1:0] OP_LOD = OPC_W'(1);
  localparam logic [OPC_W-1:0] OP_STR = OPC_W'(2);
  localparam logic [OPC_W-1:0] OP_SWP = OPC_W'(3);
  localparam logic [OPC_W-1:0] OP_BRA = OPC_W'(4);
  localparam logic [OPC_W-1:0] OP_BRR = OPC_W'(5);
  localparam logic [OPC_W-1:0] OP_BNE = OPC_W'(6);
  localparam logic [OPC_W-1:0] OP_BNR = OPC_W'(7);
  localparam logic [OPC_W-1:0] OP_ALU = OPC_W'(8);
  localparam logic [OPC_W-1:0] OP_HLT = OPC_W'(15);

  state_t state, next_state;

  logic is_lod, is_str, is_swp, is_bra, is_brr, is_bne, is_bnr, is_alu, is_hlt;
  logic is_imm, hit, taken;

  assign is_lod = (opcode == OP_LOD);
  assign is_str = (opcode == OP_STR);
  assign is_swp = (opcode == OP_SWP);
  assign is_bra = (opcode == OP_BRA);
  assign is_brr = (opcode == OP_BRR);
  assign is_bne = (opcode == OP_BNE);
  assign is_bnr = (opcode == OP_BNR);
  assign is_alu = (opcode == OP_ALU);
  assign is_hlt = (opcode == OP_HLT);
  assign is_imm = (mm == MM_W'(IMM_MM));
  assign hit    = |(mm & stat);
  assign taken  = ((is_bra | is_brr) & ((mm == '0) | hit)) |
                  ((is_bne | is_bnr) & ~hit);

  always_ff @(posedge clk or posedge rst_f) begin
    if (rst_f) state <= S_START;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    mem_req    = 1'b0;
    dm_we      = 1'b0;
    mm_sel     = 1'b0;
    rf_we      = 1'b0;
    alu_op     = 2'b10;
    wb_sel     = 2'b00;
    rb_sel     = 1'b0;
    br_sel     = 1'b0;
    ir_load    = 1'b0;
    pc_sel     = 1'b0;
    pc_write   = 1'b0;
    pc_rst     = 1'b0;
    halted     = 1'b0;
    case (state)
      S_START: begin
        pc_rst     = 1'b1;
        next_state = S_FETCH;
      end
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_load    = 1'b1;
          pc_write   = 1'b1;
          next_state = S_DECODE;
        end
      end
      S_DECODE: begin
        br_sel   = is_bra | is_bne;
        pc_sel   = taken;
        pc_write = taken;
        rb_sel   = is_alu & is_imm;
        if (is_hlt)                                next_state = S_HALT;
        else if (is_alu | is_lod | is_str | is_swp) next_state = S_EXECUTE;
        else                                       next_state = S_FETCH;
      end
      S_EXECUTE: begin
        if (is_alu) begin
          alu_op     = is_imm ? 2'b01 : 2'b00;
          rb_sel     = is_imm;
          next_state = S_WB;
        end else if (is_lod | is_str) begin
          alu_op     = 2'b11;
          next_state = S_MEM;
        end else if (is_swp) begin
          next_state = S_WB;
        end else begin
          next_state = S_FETCH;
        end
      end
      S_MEM: begin
        mem_req = 1'b1;
        mm_sel  = 1'b1;
        alu_op  = 2'b11;
        dm_we   = is_str;
        if (mem_ready) next_state = is_lod ? S_WB : S_FETCH;
      end
      S_WB: begin
        rf_we      = 1'b1;
        wb_sel     = is_lod ? 2'b01 : (is_swp ? 2'b10 : 2'b00);
        next_state = is_swp ? S_WB2 : S_FETCH;
      end
      S_WB2: begin
        rf_we      = 1'b1;
        wb_sel     = 2'b11;
        next_state = S_FETCH;
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: next_state = S_START;
    endcase
  end

endmodule

// File: tb/tb_ctrl_mc.sv
// Self-checking bench for ctrl_mc: directed steps plus random instruction stream,
// expected strobes built per cycle from the instruction rules.
module tb_ctrl_mc;
  logic       clk = 1'b0;
  logic       rst_f = 1'b1;
  logic [3:0] opcode = '0;
  logic [3:0] mm = '0;
  logic [3:0] stat = '0;
  logic       mem_ready = 1'b0;
  logic       mem_req, dm_we, mm_sel, rf_we, rb_sel, br_sel, ir_load;
  logic       pc_sel, pc_write, pc_rst, halted;
  logic [1:0] alu_op, wb_sel;
  logic [14:0] outs;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ctrl_mc #(.OPC_W(4), .MM_W(4), .IMM_MM(8)) dut (
    .clk(clk), .rst_f(rst_f), .opcode(opcode), .mm(mm), .stat(stat),
    .mem_ready(mem_ready), .mem_req(mem_req), .dm_we(dm_we), .mm_sel(mm_sel),
    .rf_we(rf_we), .alu_op(alu_op), .wb_sel(wb_sel), .rb_sel(rb_sel),
    .br_sel(br_sel), .ir_load(ir_load), .pc_sel(pc_sel), .pc_write(pc_write),
    .pc_rst(pc_rst), .halted(halted)
  );

  assign outs = {mem_req, dm_we, mm_sel, rf_we, alu_op, wb_sel, rb_sel, br_sel,
                 ir_load, pc_sel, pc_write, pc_rst, halted};

  // Expected output vector; everything else 0, alu_op defaults to 10.
  function automatic logic [14:0] ev(input logic req = 0, input logic we = 0,
      input logic msel = 0, input logic rfw = 0, input logic [1:0] aop = 2'b10,
      input logic [1:0] wbs = 0, input logic rbs = 0, input logic brs = 0,
      input logic irl = 0, input logic pcs = 0, input logic pcw = 0,
      input logic pcr = 0, input logic hlt = 0);
    return {req, we, msel, rfw, aop, wbs, rbs, brs, irl, pcs, pcw, pcr, hlt};
  endfunction

  task automatic check(input logic [14:0] exp, input string tag);
    checks++;
    assert (outs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, outs, exp);
    end
  endtask

  // One clock cycle: drive inputs after the falling edge, then check outputs.
  task automatic cyc(input logic [3:0] op, input logic [3:0] m, input logic rdy,
                     input logic [3:0] st, input logic [14:0] exp, input string tag);
    @(negedge clk);
    opcode = op; mm = m; mem_ready = rdy; stat = st;
    #1;
    check(exp, tag);
  endtask

  function automatic logic [3:0] rs();
    return 4'($urandom_range(0, 15));
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // Runs one instruction through fetch to retirement with the given waits.
  task automatic run_instr(input logic [3:0] op, input logic [3:0] m,
                           input logic [3:0] st, input int fw, input int mw);
    bit  is_br, taken, alu, imm, memop;
    logic [1:0] wbs;
    for (int i = 0; i < fw; i++)
      cyc(op, m, 1'b0, rs(), ev(.req(1)), "fetch_wait");
    cyc(op, m, 1'b1, rs(), ev(.req(1), .irl(1), .pcw(1)), "fetch_go");
    is_br = (op >= 4 && op <= 7);
    if (op == 4 || op == 5) taken = (m == 0) || ((m & st) != 0);
    else if (op == 6 || op == 7) taken = ((m & st) == 0);
    else taken = 0;
    alu = (op == 8);
    imm = (m == 4'd8);
    cyc(op, m, rb(), st, ev(.brs(op == 4 || op == 6), .pcs(taken), .pcw(taken),
        .rbs(alu && imm)), "decode");
    if (op == 15) begin
      for (int i = 0; i < 6; i++)
        cyc(op, m, rb(), rs(), ev(.hlt(1)), "halt");
      return;
    end
    if (!(alu || (op >= 1 && op <= 3)) || is_br) return;
    memop = (op == 1 || op == 2);
    if (alu) cyc(op, m, rb(), rs(), ev(.aop(imm ? 2'b01 : 2'b00), .rbs(imm)), "exec_alu");
    else if (memop) cyc(op, m, rb(), rs(), ev(.aop(2'b11)), "exec_mem");
    else cyc(op, m, rb(), rs(), ev(), "exec_swp");
    if (memop) begin
      for (int i = 0; i < mw; i++)
        cyc(op, m, 1'b0, rs(), ev(.req(1), .msel(1), .aop(2'b11), .we(op == 2)), "mem_wait");
      cyc(op, m, 1'b1, rs(), ev(.req(1), .msel(1), .aop(2'b11), .we(op == 2)), "mem_go");
      if (op == 2) return;
    end
    wbs = (op == 1) ? 2'b01 : (op == 3) ? 2'b10 : 2'b00;
    cyc(op, m, rb(), rs(), ev(.rfw(1), .wbs(wbs)), "wb");
    if (op == 3) cyc(op, m, rb(), rs(), ev(.rfw(1), .wbs(2'b11)), "wb2");
  endtask

  initial begin
    // reset and first FETCH one cycle after release
    @(negedge clk); #1;
    check(ev(.pcr(1)), "reset_start");
    @(negedge clk); rst_f = 1'b0; #1;
    check(ev(.pcr(1)), "start_after_release");

    run_instr(4'd8, 4'd0, 4'd0, 0, 0);          // ALU ADD
    run_instr(4'd5, 4'b0100, 4'b0100, 0, 0);    // BRR taken
    run_instr(4'd6, 4'b0100, 4'b0100, 0, 0);    // BNE not taken
    run_instr(4'd6, 4'b0000, 4'b0100, 0, 0);    // BNE taken
    run_instr(4'd2, 4'd3, 4'd0, 3, 3);          // STR with stalls
    run_instr(4'd1, 4'd3, 4'd0, 0, 0);          // LOD
    run_instr(4'd3, 4'd0, 4'd0, 0, 0);          // SWP
    run_instr(4'd8, 4'd8, 4'd0, 1, 0);          // ALU immediate
    run_instr(4'd11, 4'd2, 4'd0, 0, 0);         // undefined -> NOOP

    for (int n = 0; n < 300; n++) begin
      logic [3:0] op, m;
      op = 4'($urandom_range(0, 14));
      case ($urandom_range(0, 3))
        0: m = 4'd0;
        1: m = 4'd8;
        default: m = rs();
      endcase
      run_instr(op, m, rs(), $urandom_range(0, 3), $urandom_range(0, 3));
    end

    // reset mid-MEM of STR drops dm_we immediately
    cyc(4'd2, 4'd1, 1'b1, 4'd0, ev(.req(1), .irl(1), .pcw(1)), "rst_fetch");
    cyc(4'd2, 4'd1, 1'b0, 4'd0, ev(), "rst_decode");
    cyc(4'd2, 4'd1, 1'b0, 4'd0, ev(.aop(2'b11)), "rst_exec");
    cyc(4'd2, 4'd1, 1'b0, 4'd0, ev(.req(1), .msel(1), .aop(2'b11), .we(1)), "rst_mem");
    rst_f = 1'b1; #1;
    check(ev(.pcr(1)), "rst_mid_mem");
    @(negedge clk); rst_f = 1'b0; #1;
    check(ev(.pcr(1)), "start_after_mid_rst");

    run_instr(4'd8, 4'd0, 4'd0, 0, 0);
    run_instr(4'd15, 4'd0, 4'd0, 2, 0);         // HLT

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
